// File: rtl/ready_skid_reg.sv
// Valid/ready register slice with a skid slot so in_ready comes straight from a flop.
// Optional stall counter enabled by defining READY_SKID_REG_STATS_EN.
module ready_skid_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
`ifdef READY_SKID_REG_STATS_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] main_nx;
  logic [DATA_WIDTH-1:0] skid_nx;
  logic [1:0]            occ_nx;
  logic                  in_xfer;
  logic                  out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_nx = state;
    main_nx  = out_data;
    skid_nx  = skid;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nx = BUSY;
          main_nx  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_nx = in_data;
        end else if (in_xfer) begin
          state_nx = FULL;
          skid_nx  = in_data;
        end else if (out_xfer) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move
        if (out_ready) begin
          state_nx = BUSY;
          main_nx  = skid;
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  always_comb begin
    occ_nx = 2'd0;
    unique case (state_nx)
      EMPTY:   occ_nx = 2'd0;
      BUSY:    occ_nx = 2'd1;
      FULL:    occ_nx = 2'd2;
      default: occ_nx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_data  <= '0;
      skid      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nx;
      out_data  <= main_nx;
      skid      <= skid_nx;
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
      occupancy <= occ_nx;
    end
  end

`ifdef READY_SKID_REG_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (out_valid && !out_ready &&
                 (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
